// File: rtl/simd_lsu.sv
// Load/store sequencer between the SIMD execute stage and the SRAM data port.
// Splits 128-bit vector accesses into four word beats and handles scalar byte/half/word alignment.
module simd_lsu (
    input  logic         clk,
    input  logic         resetn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic         req_vec,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic         resp_valid,
    output logic         resp_err,
    output logic [127:0] resp_rdata,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    output logic [3:0]   dmem_wmask,
    output logic         dmem_write,
    output logic         dmem_valid,
    input  logic [31:0]  dmem_rdata,
    input  logic         dmem_resp_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t         state;
    logic [31:0]    addr_q;
    logic [127:0]   wdata_q;
    logic [1:0]     size_q;
    logic           sgn_q;
    logic           write_q;
    logic           vec_q;
    logic [1:0]     beat;
    logic [2:0]     rsp_cnt;

    logic           bad;
    logic [1:0]     next_beat;
    logic [31:0]    next_addr;
    logic           is_last;
    logic           capture;
    logic           final_rsp;
    logic [31:0]    load_word;

    function automatic logic [31:0] beat_wdata(input logic vec, input logic [1:0] size,
                                               input logic [127:0] wd, input logic [1:0] idx);
        logic [31:0] w;
        if (vec) begin
            w = wd[{idx, 5'd0} +: 32];
        end else begin
            case (size)
                2'd0:    w = {4{wd[7:0]}};
                2'd1:    w = {2{wd[15:0]}};
                default: w = wd[31:0];
            endcase
        end
        return w;
    endfunction

    function automatic logic [3:0] beat_wmask(input logic write, input logic vec,
                                              input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        if (!write) begin
            m = 4'h0;
        end else if (vec) begin
            m = 4'hF;
        end else begin
            case (size)
                2'd0:    m = 4'b0001 << lo;
                2'd1:    m = 4'b0011 << lo;
                default: m = 4'hF;
            endcase
        end
        return m;
    endfunction

    // Scalar load data sits at the byte lane selected by the low address bits.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] s;
        logic [31:0] ext;
        s = rd >> {lo, 3'b000};
        case (size)
            2'd0:    ext = sgn ? {{24{s[7]}}, s[7:0]} : {24'd0, s[7:0]};
            2'd1:    ext = sgn ? {{16{s[15]}}, s[15:0]} : {16'd0, s[15:0]};
            default: ext = s;
        endcase
        return ext;
    endfunction

    always_comb begin
        bad = 1'b0;
        if (req_vec) begin
            bad = (req_addr[3:0] != 4'd0);
        end else begin
            case (req_size)
                2'd0:    bad = 1'b0;
                2'd1:    bad = req_addr[0];
                2'd2:    bad = (req_addr[1:0] != 2'd0);
                default: bad = 1'b1;
            endcase
        end
    end

    assign next_beat = beat + 2'd1;
    assign next_addr = addr_q + {28'd0, next_beat, 2'b00};
    assign is_last   = (beat == (vec_q ? 2'd3 : 2'd0));
    // Read responses trail the beats by one cycle, so they are collected in ISSUE as well as DRAIN.
    assign capture   = dmem_resp_valid && !write_q && (state == ISSUE || state == DRAIN);
    assign final_rsp = capture && (rsp_cnt == (vec_q ? 3'd3 : 3'd0));
    assign load_word = vec_q ? dmem_rdata : load_extract(size_q, sgn_q, addr_q[1:0], dmem_rdata);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            dmem_write <= 1'b0;
            dmem_valid <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            write_q    <= 1'b0;
            vec_q      <= 1'b0;
            beat       <= '0;
            rsp_cnt    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (capture) begin
                resp_rdata[{rsp_cnt[1:0], 5'd0} +: 32] <= load_word;
                rsp_cnt <= rsp_cnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        sgn_q      <= req_signed;
                        write_q    <= req_write;
                        vec_q      <= req_vec;
                        beat       <= 2'd0;
                        rsp_cnt    <= 3'd0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b0;
                        if (bad) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            dmem_valid <= 1'b1;
                            dmem_write <= req_write;
                            dmem_addr  <= req_addr;
                            dmem_wdata <= beat_wdata(req_vec, req_size, req_wdata, 2'd0);
                            dmem_wmask <= beat_wmask(req_write, req_vec, req_size, req_addr[1:0]);
                        end
                    end
                end
                ISSUE: begin
                    if (is_last) begin
                        dmem_valid <= 1'b0;
                        dmem_write <= 1'b0;
                        dmem_wmask <= 4'h0;
                        if (write_q) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat       <= next_beat;
                        dmem_addr  <= next_addr;
                        dmem_wdata <= beat_wdata(vec_q, size_q, wdata_q, next_beat);
                        dmem_wmask <= beat_wmask(write_q, vec_q, size_q, next_addr[1:0]);
                    end
                end
                DRAIN: begin
                    if (final_rsp) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/simd_lsu.md
# simd_lsu

Load/store sequencer that initiates traffic on the core's SRAM data port (dmem_* interface) on behalf of the SIMD pipeline. It accepts one scalar (byte/half/word) or 128-bit vector load/store request at a time. It splits vector accesses into four word beats issued back-to-back, and builds byte write masks. It also aligns and sign/zero-extends scalar load data and returns a single completion pulse. It sits between the execute stage and the `sram` data port.

## Interface
- No parameters; data port fixed at 32 bits, vector width fixed at 128 bits (4 beats).
- `clk` in 1: single clock, all logic on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_vec` in 1: 1 = 128-bit vector access (`req_size` ignored).
- `req_size` in 2: scalar size. 0 = byte, 1 = half, 2 = word; 3 is treated as misaligned/illegal.
- `req_signed` in 1: sign-extend scalar loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 128: store data. Scalar uses [31:0]; vector word i is [32i+31:32i].
- `resp_valid` out 1: one-cycle completion pulse, no backpressure.
- `resp_err` out 1: valid with `resp_valid`; misaligned/illegal request.
- `resp_rdata` out 128: load result, valid with `resp_valid`. Zero for stores and errors; scalar result in [31:0] with [127:32] = 0.
- `dmem_addr` out 32, `dmem_wdata` out 32, `dmem_wmask` out 4, `dmem_write` out 1, `dmem_valid` out 1: request to SRAM.
- `dmem_rdata` in 32, `dmem_resp_valid` in 1: SRAM read response, one cycle after a read request.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- All outputs are registered.
- Reset values:
  - State is IDLE.
  - Every output is 0 except `req_ready`, which is 1.
- Accepting a request in IDLE latches addr, wdata, size, signed, write and vec into the request registers.
- Alignment check at acceptance:
  - vec requires addr[3:0] = 0.
  - half requires addr[0] = 0.
  - word requires addr[1:0] = 0.
  - size 3 is illegal.
  - On failure, go to DONE with `resp_err` = 1 and issue no dmem traffic.
- ISSUE issues one beat per cycle with `dmem_valid` = 1. Beat count is 4 for vec and 1 for scalar.
- Beat i addresses `req_addr + 4*i`.
- Vector store beats:
  - `dmem_wmask` = 4'hF.
  - `dmem_wdata` = word i.
- Scalar store beats:
  - Byte: wdata = replicated byte, wmask = 4'b0001 << addr[1:0].
  - Half: wdata = replicated half, wmask = 4'b0011 << addr[1:0].
  - Word: wmask = 4'hF.
- Reads drive `dmem_write` = 0 and `dmem_wmask` = 0.
- Outside ISSUE: `dmem_valid`, `dmem_write` and `dmem_wmask` are 0, and `dmem_addr`/`dmem_wdata` hold their last value.
- Stores go from ISSUE directly to DONE after the last beat. SRAM writes have no response.
- Loads go from ISSUE to DRAIN after the last beat.
- Load response capture:
  - A 3-bit response counter counts `dmem_resp_valid` pulses.
  - Response k is written to `resp_rdata` word k.
  - DRAIN goes to DONE in the cycle the final response is captured.
- Scalar load extraction:
  - Shift `dmem_rdata` right by addr[1:0]*8.
  - Take 8 or 16 bits and sign- or zero-extend to 32 bits per `req_signed`.
  - Word loads pass `dmem_rdata` through unchanged.
- DONE asserts `resp_valid` for one cycle, then goes to IDLE. `req_ready` is 0 in DONE.
- `dmem_resp_valid` in IDLE, DONE or a store sequence is ignored.
- Address wrap: `req_addr + 4*i` wraps modulo 2^32.
- `resetn` low in any state:
  - Go to IDLE next cycle.
  - Pending beats and responses are abandoned and no `resp_valid` is produced.
  - Late `dmem_resp_valid` after reset is ignored.

## Timing
Request accepted at cycle T.
- Vector load: `dmem_valid` T+1..T+4, `dmem_resp_valid` T+2..T+5, `resp_valid` T+6. Next accept is possible at T+7.
- Scalar load: `dmem_valid` T+1, response T+2, `resp_valid` T+3.
- Vector store: `dmem_valid` T+1..T+4, `resp_valid` T+5.
- Scalar store: `dmem_valid` T+1, `resp_valid` T+2.
- Misaligned/illegal request: `resp_valid` with `resp_err` at T+1; `dmem_valid` never asserts.
- Read data is sampled in the cycle `dmem_resp_valid` is high. `dmem_rdata` is only valid then.

## Test plan
- Vector store of 0x44444444_33333333_22222222_11111111 to 0x100, then vector load from 0x100:
  - Store: 4 beats with wmask F at 0x100..0x10C, `resp_valid` at T+5.
  - Load: `resp_rdata` equals the stored value, `resp_valid` at T+6, `resp_err` = 0.
- Scalar byte store 0xA5 to 0x203 into word 0:
  - Store drives wmask 4'b1000 and wdata 0xA5A5A5A5.
  - Signed byte load at 0x203 returns 0xFFFFFFA5.
  - Unsigned byte load at 0x203 returns 0x000000A5.
- Half store 0x8001 to 0x302, then signed half load returns 0xFFFF8001, word load at 0x300 returns 0x80010000 (word initially 0).
- Misaligned requests (vec at 0x104, half at 0x301, word at 0x302, size 3) each give `resp_err` = 1 at T+1 and zero dmem activity.
- `resetn` low at T+3 of a vector load:
  - No `resp_valid` follows.
  - `req_ready` = 1 the cycle after reset releases.
  - A stray `dmem_resp_valid` is ignored.
- Back-to-back requests with `req_valid` held high: each is accepted only in IDLE, and exactly one `resp_valid` is produced per accept, in order.
